spi_master: RTL and testbench

Single-byte SPI master that generates the serial bus (`ss`, `sclk`, `mosi`) driven into the team's SPI slave and captures its `miso` reply. It sits directly upstream of the slave: a host-side parallel handshake (`start`/`tx_data` in, `done`/`rx_data` out) is converted into one 8-bit, MSB-first, mode-0 frame per request. Bus timing is derived from the single system clock through a programmable divider. The slave samples on rising `sclk` edges via its own edge detector, so `sclk` is held slow enough for that detection.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_div.sv | 34 +++
 rtl/spi_master.sv | 137 +++++++++++++
 tb/tb_spi_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, word width and bit-counter width.
// Used by the master and the slave so both agree on the frame length.
package spi_pkg;

    localparam int SPI_WORD_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI master. Counts CLK_DIV clk cycles per bus phase and
// flags the final cycle with phase_end. The FSM drives reload on every state
// change (and while idle), so the count always starts at zero in a new phase.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic phase_end
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on reload, otherwise advance.
    always_comb begin
        cnt_d = reload ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign phase_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// Single-byte, MSB-first, mode-0 SPI master with a programmable sclk divider.
// Optional build macro SPI_MASTER_RX_EN: when defined, miso is shifted into an
// RX register and published on rx_data at frame end; otherwise rx_data is 0.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SPI_WORD_W-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  ss,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST = SPI_BIT_CNT_W'(SPI_WORD_W - 1);

    spi_state_e               state_q, state_d;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SPI_WORD_W-1:0]    tx_q, tx_d;
    logic                     done_q, done_d;
    logic                     phase_end;
    logic                     reload;
    logic                     frame_end;

    // Hold the timer at zero while idle and restart it on every state change.
    assign reload    = (state_d != state_q) || (state_q == ST_IDLE);
    assign frame_end = (state_q == ST_LOW) && (state_d == ST_GAP);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .reload    (reload),
        .phase_end (phase_end)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: each bus phase lasts one divider period.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)     state_d = ST_SETUP;
            ST_SETUP: if (phase_end) state_d = ST_HIGH;
            ST_HIGH:  if (phase_end) state_d = ST_LOW;
            ST_LOW:   if (phase_end) state_d = (bit_cnt_q == BIT_LAST) ? ST_GAP : ST_HIGH;
            ST_GAP:   if (phase_end) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the current state.
    always_comb begin
        ss   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        busy = 1'b1;
        unique case (state_q)
            ST_IDLE:  busy = 1'b0;
            ST_SETUP: begin ss = 1'b0; mosi = tx_q[SPI_WORD_W-1]; end
            ST_HIGH:  begin ss = 1'b0; sclk = 1'b1; mosi = tx_q[SPI_WORD_W-1]; end
            ST_LOW:   begin ss = 1'b0; mosi = tx_q[SPI_WORD_W-1]; end
            default:  ;
        endcase
    end

    // TX shift register, bit counter and done pulse.
    always_comb begin
        tx_d      = tx_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = frame_end;
        if (state_q == ST_IDLE && start) begin
            tx_d      = tx_data;
            bit_cnt_d = '0;
        end
        // Shifting at the end of HIGH presents the next bit on entry to LOW.
        if (state_q == ST_HIGH && phase_end) tx_d = {tx_q[SPI_WORD_W-2:0], 1'b0};
        if (state_q == ST_LOW && phase_end && bit_cnt_q != BIT_LAST) bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q      <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    assign done = done_q;

`ifdef SPI_MASTER_RX_EN
    logic [SPI_WORD_W-1:0] rx_q, rx_d;
    logic [SPI_WORD_W-1:0] rx_data_q, rx_data_d;

    // RX shift on the last HIGH cycle; publish the byte as the frame ends.
    always_comb begin
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        if (state_q == ST_HIGH && phase_end) rx_d = {rx_q[SPI_WORD_W-2:0], miso};
        if (frame_end) rx_data_d = rx_q;
    end

    // RX registers; rx_data is cleared by reset so a stale byte never survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q      <= '0;
            rx_data_q <= '0;
        end else begin
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a D=4 instance for framing, timing,
// reset and ignore-while-busy cases, and a D=2 instance for back-to-back frames.
// Expected rx bytes go into a scoreboard queue when a frame starts and are
// compared when done pulses.
module tb_spi_master;

    localparam int D4 = 4;
    localparam int D2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [7:0] tx_data, tx2;
    logic       busy, done, ss, sclk, mosi, miso;
    logic       busy2, done2, ss2, sclk2, mosi2, miso2;
    logic [7:0] rx_data, rx2;
    logic       loop_en, miso_tie;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    assign miso  = loop_en ? mosi : miso_tie;
    assign miso2 = mosi2;

    spi_master #(.CLK_DIV(D4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(D2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2),
        .busy(busy2), .done(done2), .rx_data(rx2),
        .ss(ss2), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
    );

    // Byte the DUT should report for a given miso stream.
    function automatic logic [7:0] rx_exp(input logic [7:0] raw);
`ifdef SPI_MASTER_RX_EN
        return raw;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full frame on the D=4 instance; cycle 1 is the cycle after acceptance.
    task automatic frame4(input logic [7:0] tx, input logic [7:0] rx_expected, input bit mid_start);
        int         rises    = 0;
        int         dones    = 0;
        int         ss_falls = 0;
        logic [7:0] bits     = 8'h00;
        logic       prev_sclk = 1'b0;
        logic       prev_ss;
        bit         fin = 1'b0;
        sb_q.push_back(rx_expected);
        start   = 1'b1;
        tx_data = tx;
        step();
        start   = 1'b0;
        tx_data = 8'h00;
        check("accept_ss", ss, 1'b0);
        check("accept_busy", busy, 1'b1);
        check("accept_mosi", mosi, tx[7]);
        prev_ss = ss;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            if (sclk && !prev_sclk) begin
                check("rise_time", cyc, 1 + D4 + 2 * D4 * rises);
                if (rises < 8) bits = {bits[6:0], mosi};
                rises++;
            end
            prev_sclk = sclk;
            if (!ss && prev_ss) ss_falls++;
            prev_ss = ss;
            if (done) begin
                dones++;
                check("done_time", cyc, 1 + 17 * D4);
                check("done_ss", ss, 1'b1);
                if (sb_q.size() == 0) check("sb_empty", 1, 0);
                else                  check("rx_data", rx_data, sb_q.pop_front());
            end
            if (!busy) begin
                check("idle_time", cyc, 1 + 18 * D4);
                fin = 1'b1;
            end
            start   = mid_start && (cyc == 30);
            tx_data = (mid_start && cyc == 30) ? 8'h3C : 8'h00;
            if (!fin) step();
        end
        check("busy_drop_seen", fin, 1'b1);
        check("sclk_rises", rises, 8);
        check("mosi_bits", bits, tx);
        check("done_count", dones, 1);
        check("ss_extra_falls", ss_falls, 0);
    endtask

    initial begin
        int         dones2;
        int         last_done;
        int         rise_t;
        int         gaps_seen;
        logic       prev_ss2;
        logic [7:0] sb2_q[$];

        rst      = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        tx_data  = 8'h00;
        tx2      = 8'h00;
        loop_en  = 1'b1;
        miso_tie = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst_ss", ss, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_ss2", ss2, 1'b1);
        check("rst_sclk2", sclk2, 1'b0);
        rst = 1'b0;
        step();

        // Loopback 0xA5.
        frame4(8'hA5, rx_exp(8'hA5), 1'b0);

        // miso tied high, all-zero TX.
        loop_en  = 1'b0;
        miso_tie = 1'b1;
        frame4(8'h00, rx_exp(8'hFF), 1'b0);
        step();
        check("rx_hold", rx_data, rx_exp(8'hFF));
        loop_en = 1'b1;

        // A start pulse mid-frame must be ignored.
        frame4(8'hC3, rx_exp(8'hC3), 1'b1);
        repeat (4) begin
            step();
            check("no_queued_frame", ss, 1'b1);
        end

        // Reset during the 4th HIGH phase (cycles 29..32 after acceptance).
        start   = 1'b1;
        tx_data = 8'h5A;
        step();
        start   = 1'b0;
        repeat (29) step();
        check("mid_high_sclk", sclk, 1'b1);
        rst = 1'b1;
        step();
        check("midrst_ss", ss, 1'b1);
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_mosi", mosi, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_rx_data", rx_data, 8'h00);
        // Reset takes priority over a simultaneous start.
        start = 1'b1;
        step();
        check("rst_beats_start", busy, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (6) begin
            step();
            check("post_rst_no_done", done, 1'b0);
        end
        frame4(8'h81, rx_exp(8'h81), 1'b0);

        // Back-to-back frames on the D=2 instance with start held high.
        // ss stays high through the D-cycle GAP plus the one IDLE cycle in
        // which the held start is sampled, then falls for the next frame.
        dones2    = 0;
        last_done = 0;
        rise_t    = 0;
        gaps_seen = 0;
        prev_ss2  = 1'b1;
        start2    = 1'b1;
        tx2       = 8'h96;
        step();
        for (int cyc = 1; cyc <= 200 && dones2 < 3; cyc++) begin
            if (!ss2 && prev_ss2) begin
                sb2_q.push_back(rx_exp(8'h96));
                if (rise_t > 0) begin
                    check("b2b_ss_high", cyc - rise_t, D2 + 1);
                    gaps_seen++;
                end
            end
            if (ss2 && !prev_ss2) rise_t = cyc;
            prev_ss2 = ss2;
            if (done2) begin
                dones2++;
                check("b2b_done_ss", ss2, 1'b1);
                if (last_done > 0) check("b2b_period", cyc - last_done, 18 * D2 + 1);
                else               check("b2b_first_done", cyc, 1 + 17 * D2);
                last_done = cyc;
                if (sb2_q.size() == 0) check("b2b_sb_empty", 1, 0);
                else                   check("b2b_rx", rx2, sb2_q.pop_front());
            end
            step();
        end
        start2 = 1'b0;
        check("b2b_done_count", dones2, 3);
        check("b2b_gaps_seen", gaps_seen, 2);
        check("b2b_busy_held", busy2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
